// File: rtl/i2c_reg_seq.sv
`default_nettype none
// ============================================================================
// Module      : i2c_reg_seq
// Description : Register-transaction sequencer in front of the I2C byte
//               controller. Takes one register read or write command and
//               walks the byte controller through the byte phases:
//                 write : {dev,0}  reg  data(stop)
//                 read  : {dev,0}  reg  {dev,1}(rep. start)  rx-byte(NACK,stop)
//               It then reports completion, read data and sticky fault flags.
//
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               cmd_valid/ready   - command handshake (ready only in idle)
//               cmd_rd            - 1 = register read, 0 = register write
//               dev_addr, reg_addr, wr_data - command fields
//               done              - one-cycle pulse when a command ends
//               rd_data           - last successfully read byte
//               nack, timeout     - sticky fault flags (cleared by rst only)
//               i2c_en/start/stop/rw/ack_o, i2c_out_byte - byte ctrl inputs
//               i2c_busy, i2c_err, i2c_in_byte           - byte ctrl outputs
//
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_reg_seq #(
    parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    // command side
    input  logic       cmd_valid,
    input  logic       cmd_rd,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic       cmd_ready,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       nack,
    output logic       timeout,
    // byte controller side
    output logic       i2c_en,
    output logic       i2c_start,
    output logic       i2c_stop,
    output logic       i2c_rw,
    output logic       i2c_ack_o,
    output logic [7:0] i2c_out_byte,
    input  logic       i2c_busy,
    input  logic       i2c_err,
    input  logic [7:0] i2c_in_byte
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_FAIL  = 3'd5;
    localparam logic [2:0] S_HALT  = 3'd6;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [1:0]  r_ph;          // current byte phase
    logic        r_rd;          // captured command fields
    logic [6:0]  r_dev;
    logic [7:0]  r_reg;
    logic [7:0]  r_wdata;
    logic [15:0] r_tcnt;        // cycles spent in the current phase

    logic        r_cmd_ready;
    logic        r_done;
    logic [7:0]  r_rd_data;
    logic        r_nack;
    logic        r_timeout;
    logic        r_en;
    logic        r_start;
    logic        r_stop;
    logic        r_rw;
    logic        r_ack_o;
    logic [7:0]  r_out_byte;

    // ------------------------------------------------------------------
    // Phase table: returns {start, stop, rw, ack_o, out_byte}
    // ------------------------------------------------------------------
    function automatic logic [11:0] phase_ctl(
        input logic [1:0] ph,
        input logic       rd,
        input logic [6:0] dev,
        input logic [7:0] ra,
        input logic [7:0] wd
    );
        logic [11:0] ctl;
        ctl = 12'h000;
        case (ph)
            2'd0:    ctl = {4'b1010, dev, 1'b0};
            2'd1:    ctl = {4'b0010, ra};
            2'd2:    ctl = rd ? {4'b1010, dev, 1'b1} : {4'b0110, wd};
            default: ctl = {4'b0101, 8'h00};   // receive, master NACK, stop
        endcase
        return ctl;
    endfunction

    logic [11:0] w_first_ctl;
    logic [11:0] w_next_ctl;
    logic        w_last;
    logic [15:0] w_tcnt_inc;
    logic        w_tmo;

    // Phase 0 controls come straight from the command inputs so they are
    // valid in the first ISSUE cycle.
    assign w_first_ctl = phase_ctl(2'd0, cmd_rd, dev_addr, reg_addr, wr_data);
    assign w_next_ctl  = phase_ctl(r_ph + 2'd1, r_rd, r_dev, r_reg, r_wdata);
    assign w_last      = r_rd ? (r_ph == 2'd3) : (r_ph == 2'd2);
    assign w_tcnt_inc  = r_tcnt + 16'd1;
    // Fires on the TIMEOUT_CYC-th cycle spent in ISSUE/WAIT.
    assign w_tmo       = (w_tcnt_inc == TIMEOUT_CYC);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ph        <= 2'd0;
            r_rd        <= 1'b0;
            r_dev       <= 7'd0;
            r_reg       <= 8'd0;
            r_wdata     <= 8'd0;
            r_tcnt      <= 16'd0;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_rd_data   <= 8'h00;
            r_nack      <= 1'b0;
            r_timeout   <= 1'b0;
            r_en        <= 1'b0;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
            r_rw        <= 1'b0;
            r_ack_o     <= 1'b0;
            r_out_byte  <= 8'h00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_rd        <= cmd_rd;
                        r_dev       <= dev_addr;
                        r_reg       <= reg_addr;
                        r_wdata     <= wr_data;
                        r_ph        <= 2'd0;
                        r_tcnt      <= 16'd0;
                        r_cmd_ready <= 1'b0;
                        r_en        <= 1'b1;
                        {r_start, r_stop, r_rw, r_ack_o, r_out_byte} <= w_first_ctl;
                        r_state     <= S_ISSUE;
                    end
                end

                // Hold en until the controller shows busy, so it cannot
                // miss the request.
                S_ISSUE: begin
                    if (w_tmo) begin
                        r_timeout <= 1'b1;
                        r_en      <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FAIL;
                    end else begin
                        r_tcnt <= w_tcnt_inc;
                        if (i2c_busy) begin
                            r_en    <= 1'b0;
                            r_state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    if (w_tmo) begin
                        r_timeout <= 1'b1;
                        r_en      <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FAIL;
                    end else begin
                        r_tcnt <= w_tcnt_inc;
                        if (!i2c_busy) begin
                            r_state <= S_CHECK;
                        end
                    end
                end

                // err is only meaningful here; the controller also raises
                // it during its own reset.
                S_CHECK: begin
                    if (i2c_err) begin
                        r_nack  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_FAIL;
                    end else if (w_last) begin
                        if (r_rd) begin
                            r_rd_data <= i2c_in_byte;
                        end
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ph    <= r_ph + 2'd1;
                        r_tcnt  <= 16'd0;
                        r_en    <= 1'b1;
                        {r_start, r_stop, r_rw, r_ack_o, r_out_byte} <= w_next_ctl;
                        r_state <= S_ISSUE;
                    end
                end

                S_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end

                S_FAIL: begin
                    r_state <= S_HALT;
                end

                // Only rst leaves HALT; the byte controller's error state
                // needs the same reset.
                S_HALT: begin
                    r_state <= S_HALT;
                end

                default: begin
                    r_en        <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cmd_ready    = r_cmd_ready;
    assign done         = r_done;
    assign rd_data      = r_rd_data;
    assign nack         = r_nack;
    assign timeout      = r_timeout;
    assign i2c_en       = r_en;
    assign i2c_start    = r_start;
    assign i2c_stop     = r_stop;
    assign i2c_rw       = r_rw;
    assign i2c_ack_o    = r_ack_o;
    assign i2c_out_byte = r_out_byte;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_reg_seq
// Description : Self-checking bench for i2c_reg_seq. A behavioural byte
//               controller records every byte request; expected byte lists,
//               read data and flags come from the command-level rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_reg_seq;

    typedef struct packed {
        logic       st;
        logic       sp;
        logic       rw;
        logic       ack;
        logic [7:0] b;
    } ph_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rd = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] wr_data = 8'd0;
    logic       cmd_ready, done, nack, timeout;
    logic [7:0] rd_data;
    logic       i2c_en, i2c_start, i2c_stop, i2c_rw, i2c_ack_o;
    logic [7:0] i2c_out_byte;

    // behavioural byte controller state
    logic       bc_busy = 1'b0;
    logic       bc_err = 1'b0;
    logic [7:0] bc_in = 8'h00;
    logic       i2c_err_w;
    ph_t        bc_cur;
    ph_t        ctl_now;
    int         bc_idx = 0;
    int         bc_cnt = 0;
    ph_t        seen_q[$];

    // scenario knobs and reference state
    int         nack_at_m = -1;
    logic [7:0] slave_m = 8'h00;
    bit         force_busy = 1'b0;
    logic [7:0] exp_rd = 8'h00;

    int         n_total = 0;
    int         n_bad = 0;
    int         stable_err = 0;

    assign i2c_err_w = bc_err | rst;
    assign ctl_now   = {i2c_start, i2c_stop, i2c_rw, i2c_ack_o, i2c_out_byte};

    always #5 clk = ~clk;

    i2c_reg_seq #(.TIMEOUT_CYC(16'd50)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_rd       (cmd_rd),
        .dev_addr     (dev_addr),
        .reg_addr     (reg_addr),
        .wr_data      (wr_data),
        .cmd_ready    (cmd_ready),
        .done         (done),
        .rd_data      (rd_data),
        .nack         (nack),
        .timeout      (timeout),
        .i2c_en       (i2c_en),
        .i2c_start    (i2c_start),
        .i2c_stop     (i2c_stop),
        .i2c_rw       (i2c_rw),
        .i2c_ack_o    (i2c_ack_o),
        .i2c_out_byte (i2c_out_byte),
        .i2c_busy     (bc_busy),
        .i2c_err      (i2c_err_w),
        .i2c_in_byte  (bc_in)
    );

    // Byte controller: samples en while idle, busy for 1..6 cycles,
    // reports err (sticky) on the scripted byte, returns slave data on rx.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            bc_busy <= 1'b0;
            bc_err  <= 1'b0;
            bc_in   <= 8'h00;
            bc_cnt  = 0;
        end else if (force_busy) begin
            bc_busy <= 1'b1;
        end else if (!bc_busy) begin
            if (i2c_en) begin
                bc_cur = ctl_now;
                bc_idx = seen_q.size();
                seen_q.push_back(bc_cur);
                bc_cnt = int'($urandom_range(1, 6));
                bc_busy <= 1'b1;
            end
        end else if (bc_cnt > 1) begin
            bc_cnt = bc_cnt - 1;
        end else begin
            bc_busy <= 1'b0;
            if (ctl_now != bc_cur) stable_err++;
            if (bc_idx == nack_at_m) bc_err <= 1'b1;
            bc_in <= bc_cur.rw ? 8'($urandom) : slave_m;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_outs"}, 32'({done, rd_data, nack, timeout, i2c_en, i2c_start,
                                   i2c_stop, i2c_rw, i2c_ack_o, i2c_out_byte}), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        force_busy = 1'b0;
        cmd_valid = 1'b0;
        #1;
        check_reset_outs("reset");
        @(negedge clk);
        rst = 1'b0;
        seen_q.delete();
        exp_rd = 8'h00;
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 50; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        if (i == 50) check("ready_wait", 32'd0, 32'd1);
    endtask

    task automatic drive_cmd(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                             input logic [7:0] wd);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_rd    = rd;
        dev_addr  = dev;
        reg_addr  = ra;
        wr_data   = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        dev_addr  = 7'($urandom);
        reg_addr  = 8'($urandom);
        wr_data   = 8'($urandom);
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 300; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (i == 300) check("done_wait", 32'd0, 32'd1);
    endtask

    // Compare recorded controller requests against the command's byte list.
    task automatic check_bytes(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                               input logic [7:0] wd, input int nack_at);
        ph_t e[$];
        ph_t t;
        int  n;
        t = {4'b1010, dev, 1'b0}; e.push_back(t);
        t = {4'b0010, ra};        e.push_back(t);
        if (!rd) begin
            t = {4'b0110, wd};    e.push_back(t);
        end else begin
            t = {4'b1010, dev, 1'b1}; e.push_back(t);
            t = {4'b0101, 8'h00};     e.push_back(t);
        end
        if (nack_at >= 0) begin
            while (e.size() > nack_at + 1) void'(e.pop_back());
        end
        check("nbytes", 32'(seen_q.size()), 32'(e.size()));
        n = (seen_q.size() < e.size()) ? seen_q.size() : e.size();
        for (int i = 0; i < n; i++) begin
            if (rd && i == 3)
                check("rx_ctl", 32'(seen_q[i][11:8]), 32'(e[i][11:8]));
            else
                check($sformatf("byte%0d", i), 32'(seen_q[i]), 32'(e[i]));
        end
        seen_q.delete();
    endtask

    task automatic run_cmd(input bit rd, input logic [6:0] dev, input logic [7:0] ra,
                           input logic [7:0] wd, input int nack_at, input logic [7:0] slave);
        nack_at_m = nack_at;
        slave_m   = slave;
        seen_q.delete();
        drive_cmd(rd, dev, ra, wd);
        wait_done();
        if (nack_at < 0 && rd) exp_rd = slave;
        check("rd_data", 32'(rd_data), 32'(exp_rd));
        check("nack", 32'(nack), 32'(nack_at >= 0));
        check("timeout", 32'(timeout), 32'd0);
        check_bytes(rd, dev, ra, wd, nack_at);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("ready_after", 32'(cmd_ready), 32'(nack_at < 0));
        if (nack_at >= 0) begin
            cmd_valid = 1'b1;
            repeat (8) begin
                @(negedge clk);
                check("halt_ready", 32'(cmd_ready), 32'd0);
            end
            cmd_valid = 1'b0;
            check("halt_no_issue", 32'(seen_q.size()), 32'd0);
            check("halt_nack", 32'(nack), 32'd1);
            do_reset();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        logic [6:0] dv;
        bit         rd;
        int         na;

        repeat (3) @(negedge clk);
        check_reset_outs("por");
        rst = 1'b0;
        @(negedge clk);

        // directed write, read, address NACK
        run_cmd(1'b0, 7'h1E, 8'h02, 8'h55, -1, 8'h00);
        run_cmd(1'b1, 7'h1E, 8'h03, 8'h00, -1, 8'hA7);
        run_cmd(1'b0, 7'h1E, 8'h02, 8'h55, 0, 8'h00);

        // randomized commands, occasional NACK on a transmitted byte
        for (int n = 0; n < 30; n++) begin
            rd = 1'($urandom);
            na = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            dv = 7'($urandom);
            run_cmd(rd, dv, 8'($urandom), 8'($urandom), na, 8'($urandom));
        end

        // cmd_valid held with changing fields during a write
        nack_at_m = -1;
        seen_q.delete();
        wait_ready();
        cmd_valid = 1'b1; cmd_rd = 1'b0;
        dev_addr = 7'h21; reg_addr = 8'h40; wr_data = 8'h99;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (!done) begin
                cmd_rd = 1'($urandom); dev_addr = 7'($urandom);
                reg_addr = 8'($urandom); wr_data = 8'($urandom);
            end
        end while (!done && k < 300);
        check("bi_done", 32'(done), 32'd1);
        check_bytes(1'b0, 7'h21, 8'h40, 8'h99, -1);
        cmd_rd = 1'b0; dev_addr = 7'h0B; reg_addr = 8'h7E; wr_data = 8'hC3;
        @(negedge clk);
        check("bi_ready_back", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        check("bi_accept2", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        wait_done();
        check_bytes(1'b0, 7'h0B, 8'h7E, 8'hC3, -1);
        check("bi_rd_data", 32'(rd_data), 32'(exp_rd));

        // timeout: controller stuck busy
        @(negedge clk);
        force_busy = 1'b1;
        seen_q.delete();
        wait_ready();
        cmd_valid = 1'b1; cmd_rd = 1'b0;
        dev_addr = 7'h1E; reg_addr = 8'h02; wr_data = 8'h55;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("tmo_en_issue", 32'(i2c_en), 32'd1);
        k = 0;
        for (int i = 1; i <= 120; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
        end
        check("tmo_cycles", 32'(k), 32'd50);
        check("tmo_flag", 32'(timeout), 32'd1);
        check("tmo_nack", 32'(nack), 32'd0);
        repeat (4) begin
            @(negedge clk);
            check("tmo_en_low", 32'(i2c_en), 32'd0);
        end
        check("tmo_ready", 32'(cmd_ready), 32'd0);
        do_reset();

        // reset mid-read during ph2, then a normal write
        nack_at_m = -1;
        slave_m = 8'h5A;
        seen_q.delete();
        drive_cmd(1'b1, 7'h1E, 8'h03, 8'h00);
        k = 0;
        while (seen_q.size() < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("mid_reached_ph2", 32'(seen_q.size() >= 3), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        seen_q.delete();
        exp_rd = 8'h00;
        run_cmd(1'b0, 7'h1E, 8'h02, 8'h55, -1, 8'h00);

        check("ctrl_stable", 32'(stable_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_reg_seq.md
# i2c_reg_seq

Register-transaction sequencer sitting directly upstream of the I2C byte controller in the j1_soc I2C path. Accepts one register read or write command from the J1 peripheral bus and drives the byte controller's `en/start/stop/rw/ack_o/out_byte` handshake through the 3-byte write or 4-byte read (repeated-start) sequence. Returns read data, completion pulse and fault status. The byte controller is used unmodified.

## Interface
Parameters:
- `TIMEOUT_CYC`, 16'hFFFF: max `clk` cycles allowed per byte phase before declaring a timeout.

Ports:
- `clk` in 1: system clock (same clock as the byte controller).
- `rst` in 1: reset, asynchronous, active-high.
- `cmd_valid` in 1: command request; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_rd` in 1: 1 = register read, 0 = register write.
- `dev_addr` in 7: 7-bit slave address.
- `reg_addr` in 8: target register.
- `wr_data` in 8: write payload; ignored for reads.
- `cmd_ready` out 1: 1 in IDLE only.
- `done` out 1: one-cycle pulse at transaction end (success, NACK or timeout).
- `rd_data` out 8: last successful read byte; holds until the next successful read.
- `nack` out 1: sticky; set when the controller reports `err`.
- `timeout` out 1: sticky; set on phase timeout.
- `i2c_en`, `i2c_start`, `i2c_stop`, `i2c_rw`, `i2c_ack_o` out 1 each: to the byte controller (`rw`: 1 = transmit, 0 = receive).
- `i2c_out_byte` out 8: byte to transmit.
- `i2c_busy`, `i2c_err` in 1: from the byte controller.
- `i2c_in_byte` in 8: received byte from the byte controller.

## Operation
- On acceptance, `cmd_rd`, `dev_addr`, `reg_addr` and `wr_data` are captured. The phase counter `ph` is cleared to 0.
- Phase table (`out_byte` / `start` / `stop` / `rw` / `ack_o`):
  - ph0: {dev_addr,0} / 1 / 0 / 1 / 0
  - ph1: reg_addr / 0 / 0 / 1 / 0
  - Write ph2: wr_data / 0 / 1 / 1 / 0. This is the last phase.
  - Read ph2: {dev_addr,1} / 1 (repeated start) / 0 / 1 / 0
  - Read ph3: don't care / 0 / 1 / 0 / 1 (NACK the final byte). This is the last phase.
- States and transitions:
  - IDLE → ISSUE on accept.
  - ISSUE: `i2c_en`=1, held until `i2c_busy`=1 is seen, then → WAIT.
  - WAIT: `i2c_en`=0; → CHECK when `i2c_busy`=0.
  - CHECK, in priority order:
    - If `i2c_err`=1: → FAIL and set `nack`.
    - Else if last phase: capture `i2c_in_byte` into `rd_data` (read only) and → DONE.
    - Else: `ph`+1 and → ISSUE.
  - DONE: `done`=1 for one cycle, then → IDLE.
  - FAIL: `done`=1 for one cycle, then → HALT.
  - HALT: `cmd_ready`=0 and sticky flags held until `rst`. The byte controller's error state also requires `rst`.
- Timeout:
  - A 16-bit phase counter clears on entry to ISSUE and increments in ISSUE/WAIT.
  - Reaching `TIMEOUT_CYC` sets `timeout`, drops `i2c_en`, and → FAIL.
- All `i2c_*` controls and `i2c_out_byte` are registered.
  - They are constant from ISSUE entry through the end of WAIT, because the controller loads `out_byte` on the negedge while in its idle state.
  - Outside ISSUE/WAIT: `i2c_en`=0.
- `i2c_err` is ignored outside CHECK. The controller asserts err=1 during its own reset cycle.
- `cmd_valid` outside IDLE is ignored; no queueing.

## Timing
- Reset values: `cmd_ready`=1 (IDLE), `done`=0, `rd_data`=8'h00, `nack`=0, `timeout`=0, all `i2c_*` outputs 0, `i2c_out_byte`=8'h00.
- Accept at edge N → ISSUE at N+1 with controls valid.
- Controller `busy` rises combinationally one cycle after it samples `en`, so ISSUE lasts ≥2 cycles.
- Overhead per phase is 3 cycles beyond the controller's busy time: ISSUE exit, CHECK, and the ISSUE re-entry for the next phase.
- `done` asserts the cycle after CHECK. `rd_data` updates in the same cycle as `done`.
- `cmd_ready` returns to 1 the cycle after `done`. Back-to-back commands are possible with 1 idle cycle.
- Reset mid-transaction: all state returns to reset values immediately. The SDA/SCL bus state is the byte controller's responsibility, since both blocks share `rst`.

## Test plan
- Write: dev 7'h1E, reg 8'h02, data 8'h55, slave ACKs all.
  - Required: three byte phases seen, with start only on ph0 and stop only on ph2.
  - Bus bytes are 8'h3C, 8'h02, 8'h55.
  - Required: one `done` pulse, `nack`=0, `rd_data` unchanged.
- Read: dev 7'h1E, reg 8'h03, slave returns 8'hA7.
  - Required bus sequence: 8'h3C, 8'h03, repeated start, 8'h3D, read byte with master NACK, then stop.
  - Required: `rd_data`=8'hA7 in the `done` cycle.
- Address NACK: slave does not ACK ph0.
  - Required: ph1 is never issued; `nack`=1 with `done` pulse; then `cmd_ready` stays 0 until `rst`.
- Timeout: `TIMEOUT_CYC`=16'd50, byte controller `busy` forced high.
  - Required: `timeout`=1 and `done` 50 cycles after ISSUE entry; `i2c_en`=0 thereafter.
- Busy ignore: `cmd_valid` held high with changing fields during a write.
  - Required: only the first command executes; the second is accepted the cycle `cmd_ready` returns.
- Reset mid-read: `rst` pulsed during ph2.
  - Required: all outputs return to reset values asynchronously; a subsequent write completes normally.
